vc_ctrl_array: RTL and testbench

Parametrised per-input-port virtual-channel controller for the NoC router. It instantiates VC_N independent per-VC packet state machines behind one physical input channel and sequences each packet through route latch, VC allocation and switch allocation. It replaces single-VC, single-request sequencing with:

- separate VA and SA request phases,
- credit-qualified switch requests,
- output-VC binding per packet,
- malformed-packet drop.

It sits between the input VC buffers and the router's VC/switch allocators.

---
 rtl/noc_pkg.sv | 37 +++
 rtl/vc_fsm.sv | 91 +++++++++
 rtl/vc_ctrl_array.sv | 79 +++++++
 tb/tb_vc_ctrl_array.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// noc_pkg: flit-type encodings, per-VC state type and width helpers for the router.
// Rev 1.0
package noc_pkg;

  localparam int TYPE_W = 2;

  localparam logic [TYPE_W-1:0] TYPE_HEAD     = 2'd0;
  localparam logic [TYPE_W-1:0] TYPE_BODY     = 2'd1;
  localparam logic [TYPE_W-1:0] TYPE_TAIL     = 2'd2;
  localparam logic [TYPE_W-1:0] TYPE_HEADTAIL = 2'd3;

  localparam int VC_N_DEF = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VA     = 2'd1,
    ACTIVE = 2'd2
  } vc_state_e;

  // Output-VC index width; a single VC still needs one bit.
  function automatic int vcw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int VCW = vcw_of(VC_N_DEF);

  function automatic logic is_head(input logic [TYPE_W-1:0] t);
    return (t == TYPE_HEAD) || (t == TYPE_HEADTAIL);
  endfunction

  function automatic logic is_tail(input logic [TYPE_W-1:0] t);
    return (t == TYPE_TAIL) || (t == TYPE_HEADTAIL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vc_fsm.sv
`default_nettype none
// vc_fsm: one input VC's packet sequencer (IDLE -> VA -> ACTIVE) with bound port/VC registers.
// Rev 1.0
module vc_fsm
  import noc_pkg::*;
#(
  parameter int PORT_W = 3,
  parameter int VCW    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flit_vld,
  input  logic [TYPE_W-1:0] flit_type,
  input  logic [PORT_W-1:0] route,
  input  logic              va_gnt,
  input  logic [VCW-1:0]    va_ovc,
  input  logic              crd_ok,
  input  logic              sa_gnt,
  output logic              va_req,
  output logic [PORT_W-1:0] va_port,
  output logic              sa_req,
  output logic              send,
  output logic [PORT_W-1:0] out_port,
  output logic [VCW-1:0]    out_vc,
  output logic              lck,
  output logic              drop
);

  vc_state_e         state, state_nxt;
  logic [PORT_W-1:0] port_q, port_nxt;
  logic [VCW-1:0]    ovc_q, ovc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      port_q <= '0;
      ovc_q  <= '0;
    end else begin
      state  <= state_nxt;
      port_q <= port_nxt;
      ovc_q  <= ovc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    port_nxt  = port_q;
    ovc_nxt   = ovc_q;
    va_req    = 1'b0;
    va_port   = '0;
    sa_req    = 1'b0;
    send      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (flit_vld) begin
          if (is_head(flit_type)) begin
            port_nxt  = route;
            state_nxt = VA;
          end else begin
            // Reset forces every output low, including this purely input-driven pop.
            drop = ~rst;
          end
        end
      end
      VA: begin
        va_req  = 1'b1;
        va_port = port_q;
        if (va_gnt) begin
          ovc_nxt   = va_ovc;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        sa_req = flit_vld & crd_ok;
        send   = sa_req & sa_gnt;
        // A stray HEAD mid-packet is forwarded but does not end the packet.
        if (send && is_tail(flit_type)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_port = port_q;
  assign out_vc   = ovc_q;
  assign lck      = (state != IDLE);

endmodule
`default_nettype wire

// File: rtl/vc_ctrl_array.sv
`default_nettype none
// vc_ctrl_array: per-input-port array of VC sequencers with per-VC downstream credit selection.
// Rev 1.0
module vc_ctrl_array
  import noc_pkg::*;
#(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int VC_N     = VC_N_DEF,
  parameter int PORT_N   = 5,
  localparam int PORT_W  = $clog2(PORT_N),
  localparam int VCW     = vcw_of(VC_N)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [VC_N-1:0]               flit_vld_i,
  input  logic [VC_N-1:0][TYPE_W-1:0]   flit_type_i,
  input  logic [VC_N-1:0][PORT_W-1:0]   route_i,
  output logic [VC_N-1:0]               va_req_o,
  output logic [VC_N-1:0][PORT_W-1:0]   va_port_o,
  input  logic [VC_N-1:0]               va_gnt_i,
  input  logic [VC_N-1:0][VCW-1:0]      va_ovc_i,
  input  logic [PORT_N-1:0][VC_N-1:0]   crd_avail_i,
  output logic [VC_N-1:0]               sa_req_o,
  input  logic [VC_N-1:0]               sa_gnt_i,
  output logic [VC_N-1:0]               send_o,
  output logic [VC_N-1:0][PORT_W-1:0]   out_port_o,
  output logic [VC_N-1:0][VCW-1:0]      out_vc_o,
  output logic [VC_N-1:0]               lck_o,
  output logic [VC_N-1:0]               drop_o
);

  if (VC_N < 1 || PORT_N < 2 || ROUTERID < 0 || PCHID < 0) begin : g_param_chk
    $error("vc_ctrl_array: illegal parameters VC_N=%0d PORT_N=%0d", VC_N, PORT_N);
  end

  logic [VC_N-1:0] crd_ok;

  // Explicit compare keeps non-power-of-two port/VC counts from indexing out of range.
  always_comb begin
    crd_ok = '0;
    for (int v = 0; v < VC_N; v++) begin
      for (int p = 0; p < PORT_N; p++) begin
        for (int o = 0; o < VC_N; o++) begin
          if (out_port_o[v] == PORT_W'(p) && out_vc_o[v] == VCW'(o)) begin
            crd_ok[v] = crd_avail_i[p][o];
          end
        end
      end
    end
  end

  for (genvar v = 0; v < VC_N; v++) begin : g_vc
    vc_fsm #(
      .PORT_W (PORT_W),
      .VCW    (VCW)
    ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .flit_vld  (flit_vld_i[v]),
      .flit_type (flit_type_i[v]),
      .route     (route_i[v]),
      .va_gnt    (va_gnt_i[v]),
      .va_ovc    (va_ovc_i[v]),
      .crd_ok    (crd_ok[v]),
      .sa_gnt    (sa_gnt_i[v]),
      .va_req    (va_req_o[v]),
      .va_port   (va_port_o[v]),
      .sa_req    (sa_req_o[v]),
      .send      (send_o[v]),
      .out_port  (out_port_o[v]),
      .out_vc    (out_vc_o[v]),
      .lck       (lck_o[v]),
      .drop      (drop_o[v])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_vc_ctrl_array.sv
`default_nettype none
// tb_vc_ctrl_array: directed and randomized checks of vc_ctrl_array against a packet-level model.
// Rev 1.0
module tb_vc_ctrl_array;
  import noc_pkg::*;

  localparam int VC_N   = 2;
  localparam int PORT_N = 5;
  localparam int PORT_W = 3;
  localparam int VCW    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [VC_N-1:0]             flit_vld_i  = '0;
  logic [VC_N-1:0][TYPE_W-1:0] flit_type_i = '0;
  logic [VC_N-1:0][PORT_W-1:0] route_i     = '0;
  logic [VC_N-1:0]             va_req_o;
  logic [VC_N-1:0][PORT_W-1:0] va_port_o;
  logic [VC_N-1:0]             va_gnt_i    = '0;
  logic [VC_N-1:0][VCW-1:0]    va_ovc_i    = '0;
  logic [PORT_N-1:0][VC_N-1:0] crd_avail_i = '0;
  logic [VC_N-1:0]             sa_req_o;
  logic [VC_N-1:0]             sa_gnt_i    = '0;
  logic [VC_N-1:0]             send_o;
  logic [VC_N-1:0][PORT_W-1:0] out_port_o;
  logic [VC_N-1:0][VCW-1:0]    out_vc_o;
  logic [VC_N-1:0]             lck_o;
  logic [VC_N-1:0]             drop_o;

  always #5 clk = ~clk;

  vc_ctrl_array #(
    .ROUTERID (0),
    .PCHID    (0),
    .VC_N     (VC_N),
    .PORT_N   (PORT_N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flit_vld_i  (flit_vld_i),
    .flit_type_i (flit_type_i),
    .route_i     (route_i),
    .va_req_o    (va_req_o),
    .va_port_o   (va_port_o),
    .va_gnt_i    (va_gnt_i),
    .va_ovc_i    (va_ovc_i),
    .crd_avail_i (crd_avail_i),
    .sa_req_o    (sa_req_o),
    .sa_gnt_i    (sa_gnt_i),
    .send_o      (send_o),
    .out_port_o  (out_port_o),
    .out_vc_o    (out_vc_o),
    .lck_o       (lck_o),
    .drop_o      (drop_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Input VC buffers: flit types with the route attached to each flit.
  logic [TYPE_W-1:0] fq[VC_N][$];
  logic [PORT_W-1:0] rq[VC_N][$];

  // Packet-level model: does the VC own a packet, has it been given an output VC.
  bit               busy[VC_N];
  bit               bound[VC_N];
  logic [PORT_W-1:0] m_port[VC_N];
  logic [VCW-1:0]    m_ovc[VC_N];

  logic [VC_N-1:0] obs_send, obs_lck, obs_sareq, obs_vareq, obs_drop;
  logic [VC_N-1:0][PORT_W-1:0] obs_port;
  logic [VC_N-1:0][VCW-1:0]    obs_ovc;
  int cnt_send[VC_N];
  int cnt_drop[VC_N];
  int cnt_vareq[VC_N];

  task automatic push_flit(input int v, input logic [TYPE_W-1:0] t, input logic [PORT_W-1:0] p);
    fq[v].push_back(t);
    rq[v].push_back(p);
  endtask

  task automatic push_pkt(input int v, input int len, input logic [PORT_W-1:0] p);
    if (len == 1) begin
      push_flit(v, TYPE_HEADTAIL, p);
    end else begin
      push_flit(v, TYPE_HEAD, p);
      for (int i = 1; i < len - 1; i++) push_flit(v, TYPE_BODY, p);
      push_flit(v, TYPE_TAIL, p);
    end
  endtask

  task automatic apply_flits();
    for (int v = 0; v < VC_N; v++) begin
      if (fq[v].size() != 0) begin
        flit_vld_i[v]  = 1'b1;
        flit_type_i[v] = fq[v][0];
        route_i[v]     = rq[v][0];
      end else begin
        flit_vld_i[v]  = 1'b0;
        flit_type_i[v] = TYPE_BODY;
        route_i[v]     = '0;
      end
    end
  endtask

  task automatic check_outputs();
    logic vld, crd, e_va, e_sa, e_send, e_drop, e_lck;
    logic [TYPE_W-1:0] t;
    logic [PORT_W-1:0] e_vport, e_oport;
    logic [VCW-1:0]    e_ovc;
    for (int v = 0; v < VC_N; v++) begin
      vld = flit_vld_i[v];
      t   = flit_type_i[v];
      crd = crd_avail_i[m_port[v]][m_ovc[v]];
      if (rst) begin
        e_lck = 0; e_va = 0; e_vport = '0; e_sa = 0; e_send = 0; e_drop = 0;
        e_oport = '0; e_ovc = '0;
      end else begin
        e_lck   = busy[v];
        e_va    = busy[v] && !bound[v];
        e_vport = e_va ? m_port[v] : '0;
        e_sa    = busy[v] && bound[v] && vld && crd;
        e_send  = e_sa && sa_gnt_i[v];
        e_drop  = !busy[v] && vld && (t == TYPE_BODY || t == TYPE_TAIL);
        e_oport = m_port[v];
        e_ovc   = m_ovc[v];
      end
      check($sformatf("lck[%0d]", v),      32'(lck_o[v]),      32'(e_lck));
      check($sformatf("va_req[%0d]", v),   32'(va_req_o[v]),   32'(e_va));
      check($sformatf("va_port[%0d]", v),  32'(va_port_o[v]),  32'(e_vport));
      check($sformatf("sa_req[%0d]", v),   32'(sa_req_o[v]),   32'(e_sa));
      check($sformatf("send[%0d]", v),     32'(send_o[v]),     32'(e_send));
      check($sformatf("drop[%0d]", v),     32'(drop_o[v]),     32'(e_drop));
      check($sformatf("out_port[%0d]", v), 32'(out_port_o[v]), 32'(e_oport));
      check($sformatf("out_vc[%0d]", v),   32'(out_vc_o[v]),   32'(e_ovc));
    end
  endtask

  task automatic update_model();
    bit pop;
    for (int v = 0; v < VC_N; v++) begin
      if (rst) begin
        busy[v] = 0; bound[v] = 0; m_port[v] = '0; m_ovc[v] = '0;
      end else begin
        pop = 0;
        if (!busy[v]) begin
          if (flit_vld_i[v]) begin
            if (flit_type_i[v] == TYPE_HEAD || flit_type_i[v] == TYPE_HEADTAIL) begin
              busy[v] = 1; bound[v] = 0; m_port[v] = route_i[v];
            end else begin
              pop = 1;
            end
          end
        end else if (!bound[v]) begin
          if (va_gnt_i[v]) begin
            bound[v] = 1; m_ovc[v] = va_ovc_i[v];
          end
        end else if (flit_vld_i[v] && crd_avail_i[m_port[v]][m_ovc[v]] && sa_gnt_i[v]) begin
          pop = 1;
          if (flit_type_i[v] == TYPE_TAIL || flit_type_i[v] == TYPE_HEADTAIL) busy[v] = 0;
        end
        if (pop) begin
          void'(fq[v].pop_front());
          void'(rq[v].pop_front());
        end
      end
    end
  endtask

  task automatic run_cycle();
    apply_flits();
    @(negedge clk);
    check_outputs();
    obs_send = send_o; obs_lck = lck_o; obs_sareq = sa_req_o; obs_vareq = va_req_o;
    obs_drop = drop_o; obs_port = out_port_o; obs_ovc = out_vc_o;
    for (int v = 0; v < VC_N; v++) begin
      cnt_send[v]  += int'(send_o[v]);
      cnt_drop[v]  += int'(drop_o[v]);
      cnt_vareq[v] += int'(va_req_o[v]);
    end
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic clear_counts();
    for (int v = 0; v < VC_N; v++) begin
      cnt_send[v] = 0; cnt_drop[v] = 0; cnt_vareq[v] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int v = 0; v < VC_N; v++) begin
      fq[v].delete();
      rq[v].delete();
    end
    va_gnt_i = '0; va_ovc_i = '0; sa_gnt_i = '0; crd_avail_i = '0;
    run_cycle();
    run_cycle();
    rst = 1'b0;
    clear_counts();
  endtask

  initial begin
    for (int v = 0; v < VC_N; v++) begin
      busy[v] = 0; bound[v] = 0; m_port[v] = '0; m_ovc[v] = '0;
    end
    do_reset();

    // Single HEADTAIL packet: VA grant at cycle 2, SA grant at cycle 3.
    push_pkt(0, 1, 3'd3);
    crd_avail_i[3][1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      va_gnt_i    = (c == 2) ? 2'b01 : 2'b00;
      va_ovc_i[0] = 1'b1;
      sa_gnt_i    = (c == 3) ? 2'b01 : 2'b00;
      run_cycle();
      if (c == 0) check("ht_vareq_c0", 32'(obs_vareq[0]), 32'd0);
      if (c == 1) check("ht_vareq_c1", 32'(obs_vareq[0]), 32'd1);
      if (c == 3) check("ht_send_c3", 32'(obs_send[0]), 32'd1);
      if (c == 4) begin
        check("ht_lck_c4", 32'(obs_lck[0]), 32'd0);
        check("ht_port", 32'(obs_port[0]), 32'd3);
        check("ht_ovc", 32'(obs_ovc[0]), 32'd1);
      end
    end
    check("ht_sends", 32'(cnt_send[0]), 32'd1);

    // Credit stall: 4-flit packet, credit to (1,0) gone for cycles 4..6.
    do_reset();
    push_pkt(0, 4, 3'd1);
    va_gnt_i = 2'b01; va_ovc_i = '0; sa_gnt_i = 2'b01;
    for (int c = 0; c < 11; c++) begin
      crd_avail_i       = '1;
      crd_avail_i[1][0] = !(c >= 4 && c <= 6);
      run_cycle();
      if (c >= 2 && c <= 8)
        check($sformatf("stall_sareq_c%0d", c), 32'(obs_sareq[0]), 32'(!(c >= 4 && c <= 6)));
    end
    check("stall_sends", 32'(cnt_send[0]), 32'd4);
    check("stall_lck_end", 32'(obs_lck[0]), 32'd0);

    // Malformed entry: BODY flit while vc1 is idle.
    do_reset();
    push_flit(1, TYPE_BODY, 3'd2);
    crd_avail_i = '1;
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      if (c == 0) check("mal_drop_c0", 32'(obs_drop[1]), 32'd1);
    end
    check("mal_drops", 32'(cnt_drop[1]), 32'd1);
    check("mal_vareq", 32'(cnt_vareq[1]), 32'd0);

    // Parallel VCs to port 2 with alternating switch grants.
    do_reset();
    push_pkt(0, 3, 3'd2);
    push_pkt(1, 3, 3'd2);
    crd_avail_i = '1; va_gnt_i = 2'b11; va_ovc_i[0] = 1'b0; va_ovc_i[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      sa_gnt_i = c[0] ? 2'b10 : 2'b01;
      run_cycle();
    end
    check("par_sends0", 32'(cnt_send[0]), 32'd3);
    check("par_sends1", 32'(cnt_send[1]), 32'd3);
    check("par_idle", 32'(obs_lck), 32'd0);

    // Reset after 2 of 5 flits, then leftovers are dropped and a new head restarts VA.
    do_reset();
    push_pkt(0, 5, 3'd2);
    crd_avail_i = '1; va_gnt_i = 2'b01; sa_gnt_i = 2'b01;
    for (int c = 0; c < 4; c++) run_cycle();
    check("rst_sent2", 32'(cnt_send[0]), 32'd2);
    rst = 1'b1;
    run_cycle();
    check("rst_lck", 32'(obs_lck), 32'd0);
    check("rst_send", 32'(obs_send), 32'd0);
    run_cycle();
    rst = 1'b0;
    va_gnt_i = '0;
    for (int c = 0; c < 4; c++) run_cycle();
    check("rst_leftover_dropped", 32'(fq[0].size()), 32'd0);
    push_pkt(0, 2, 3'd4);
    run_cycle();
    run_cycle();
    check("rst_restart_vareq", 32'(obs_vareq[0]), 32'd1);

    // Spurious grants while idle.
    do_reset();
    crd_avail_i = '1; va_gnt_i = 2'b11; sa_gnt_i = 2'b01;
    for (int c = 0; c < 3; c++) begin
      sa_gnt_i = c[0] ? 2'b10 : 2'b01;
      run_cycle();
    end
    check("spur_lck", 32'(obs_lck), 32'd0);
    check("spur_sends", 32'(cnt_send[0] + cnt_send[1]), 32'd0);

    // Randomized traffic with occasional stray flits and reset pulses.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(499, 0) == 0);
      for (int v = 0; v < VC_N; v++) begin
        if (fq[v].size() < 3 && $urandom_range(3, 0) == 0) begin
          if ($urandom_range(9, 0) == 0)
            push_flit(v, ($urandom_range(1, 0) != 0) ? TYPE_BODY : TYPE_TAIL, '0);
          else
            push_pkt(v, int'($urandom_range(5, 1)), PORT_W'($urandom_range(PORT_N - 1, 0)));
        end
        va_gnt_i[v] = ($urandom_range(2, 0) == 0);
        va_ovc_i[v] = VCW'($urandom_range(VC_N - 1, 0));
      end
      for (int p = 0; p < PORT_N; p++)
        for (int o = 0; o < VC_N; o++)
          crd_avail_i[p][o] = ($urandom_range(4, 0) != 0);
      case ($urandom_range(3, 0))
        0:       sa_gnt_i = 2'b01;
        1:       sa_gnt_i = 2'b10;
        default: sa_gnt_i = 2'b00;
      endcase
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
